// File: rtl/preamble_insertion.sv
// preamble_insertion
//   Transmit-side legacy 802.11a/g preamble inserter. For each payload frame it
//   emits SHORT_COUNT x 16-sample L-STF repetitions, then the L-LTF (32-sample
//   guard interval + 2 x 64-sample long symbols), then passes the payload through.
//   After a frame's last beat is taken, GAP idle cycles are forced before the next
//   frame may start.
// Ports
//   clk, reset         clock, synchronous active-high reset
//   s_valid/s_ready    payload handshake; s_data = {Q,I}, s_last marks frame end
//   m_valid/m_ready    output handshake; m_data = {Q,I}
//   m_user             segment tag: 0 = STF, 1 = LTF, 2 = DATA
//   m_last             final payload sample of the frame
// Tables hold the standard time-domain sequences in thousandths, scaled at
// elaboration by 2^(WIDTH-2)/0.2 and truncated toward zero (peak 0.161 stays
// below 2^(WIDTH-2)).
module preamble_insertion #(
  parameter int WIDTH       = 16,
  parameter int SHORT_COUNT = 10,
  parameter int GAP         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic [1:0]         m_user,
  output logic               m_last
);

  localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [7:0]      STF_LAST = 8'(16 * SHORT_COUNT - 1);
  localparam logic [7:0]      LTF_LAST = 8'd159;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [2:0] {S_IDLE, S_STF, S_LTF, S_DATA, S_GAP} state_t;

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic [GW-1:0]      gap_cnt, gap_n;
  logic               mv_n, ml_n;
  logic [2*WIDTH-1:0] md_n;
  logic [1:0]         mu_n;
  logic               free;

  function automatic logic [WIDTH-1:0] quant(input int milli);
    longint scaled;
    scaled = (longint'(milli) <<< (WIDTH - 2)) / 200;
    return scaled[WIDTH-1:0];
  endfunction

  function automatic logic [2*WIDTH-1:0] cw(input int re, input int im);
    return {quant(im), quant(re)};
  endfunction

  function automatic logic [2*WIDTH-1:0] sts(input logic [3:0] i);
    logic [2*WIDTH-1:0] w;
    case (i)
      4'd0:  w = cw(  23,   23);
      4'd1:  w = cw(-132,    2);
      4'd2:  w = cw( -13,  -79);
      4'd3:  w = cw( 143,  -13);
      4'd4:  w = cw(  92,    0);
      4'd5:  w = cw( 143,  -13);
      4'd6:  w = cw( -13,  -79);
      4'd7:  w = cw(-132,    2);
      4'd8:  w = cw(  46,   46);
      4'd9:  w = cw(   2, -132);
      4'd10: w = cw( -79,  -13);
      4'd11: w = cw( -13,  143);
      4'd12: w = cw(   0,   92);
      4'd13: w = cw( -13,  143);
      4'd14: w = cw( -79,  -13);
      default: w = cw(  2, -132);
    endcase
    return w;
  endfunction

  function automatic logic [2*WIDTH-1:0] lts(input logic [5:0] i);
    logic [2*WIDTH-1:0] w;
    case (i)
      6'd0:  w = cw( 156,    0);  6'd1:  w = cw(  -5, -120);
      6'd2:  w = cw(  40, -111);  6'd3:  w = cw(  97,   83);
      6'd4:  w = cw(  21,   28);  6'd5:  w = cw(  60,  -88);
      6'd6:  w = cw(-115,  -55);  6'd7:  w = cw( -38, -106);
      6'd8:  w = cw(  98,  -26);  6'd9:  w = cw(  53,    4);
      6'd10: w = cw(   1, -115);  6'd11: w = cw(-137,  -47);
      6'd12: w = cw(  24,  -59);  6'd13: w = cw(  59,  -15);
      6'd14: w = cw( -22,  161);  6'd15: w = cw( 119,   -4);
      6'd16: w = cw(  62,   62);  6'd17: w = cw(  37,  -98);
      6'd18: w = cw( -57,  -39);  6'd19: w = cw(-131,  -65);
      6'd20: w = cw(  82,  -92);  6'd21: w = cw(  70,  -14);
      6'd22: w = cw( -60,  -81);  6'd23: w = cw( -56,   22);
      6'd24: w = cw( -35,  151);  6'd25: w = cw(-122,   17);
      6'd26: w = cw(-127,   21);  6'd27: w = cw(  75,   74);
      6'd28: w = cw(  -3,  -54);  6'd29: w = cw( -92,  115);
      6'd30: w = cw(  92,  106);  6'd31: w = cw(  12,   98);
      6'd32: w = cw(-156,    0);  6'd33: w = cw(  12,  -98);
      6'd34: w = cw(  92, -106);  6'd35: w = cw( -92, -115);
      6'd36: w = cw(  -3,   54);  6'd37: w = cw(  75,  -74);
      6'd38: w = cw(-127,  -21);  6'd39: w = cw(-122,  -17);
      6'd40: w = cw( -35, -151);  6'd41: w = cw( -56,  -22);
      6'd42: w = cw( -60,   81);  6'd43: w = cw(  70,   14);
      6'd44: w = cw(  82,   92);  6'd45: w = cw(-131,   65);
      6'd46: w = cw( -57,   39);  6'd47: w = cw(  37,   98);
      6'd48: w = cw(  62,  -62);  6'd49: w = cw( 119,    4);
      6'd50: w = cw( -22, -161);  6'd51: w = cw(  59,   15);
      6'd52: w = cw(  24,   59);  6'd53: w = cw(-137,   47);
      6'd54: w = cw(   1,  115);  6'd55: w = cw(  53,   -4);
      6'd56: w = cw(  98,   26);  6'd57: w = cw( -38,  106);
      6'd58: w = cw(-115,   55);  6'd59: w = cw(  60,   88);
      6'd60: w = cw(  21,  -28);  6'd61: w = cw(  97,  -83);
      6'd62: w = cw(  40,  111);  default: w = cw(  -5,  120);
    endcase
    return w;
  endfunction

  // Output register may load a new beat when empty or being drained.
  assign free = !m_valid || m_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gap_n   = gap_cnt;
    mv_n    = m_valid;
    md_n    = m_data;
    mu_n    = m_user;
    ml_n    = m_last;
    s_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_valid) begin
          state_n = S_STF;
          cnt_n   = '0;
        end
      end
      S_STF: begin
        if (free) begin
          mv_n = 1'b1;
          md_n = sts(cnt[3:0]);
          mu_n = 2'd0;
          ml_n = 1'b0;
          if (cnt == STF_LAST) begin
            state_n = S_LTF;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_LTF: begin
        if (free) begin
          mv_n = 1'b1;
          // GI (cnt+32), first (cnt-32) and second (cnt-96) symbol indices are
          // all congruent to cnt+32 modulo 64.
          md_n = lts(cnt[5:0] + 6'd32);
          mu_n = 2'd1;
          ml_n = 1'b0;
          if (cnt == LTF_LAST) begin
            state_n = S_DATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_DATA: begin
        s_ready = free;
        if (free) begin
          if (s_valid) begin
            mv_n = 1'b1;
            md_n = s_data;
            mu_n = 2'd2;
            ml_n = s_last;
            if (s_last) begin
              state_n = S_GAP;
              gap_n   = '0;
            end
          end else begin
            // Underflow: drop valid, stay in DATA without reinserting preamble.
            mv_n = 1'b0;
            ml_n = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (free) begin
          mv_n = 1'b0;
          ml_n = 1'b0;
        end
        if (GAP == 0) begin
          if (free) state_n = S_IDLE;
        end else if (!m_valid) begin
          if (gap_cnt == GAP_LAST) state_n = S_IDLE;
          else                     gap_n   = gap_cnt + GW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_user  <= '0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gap_cnt <= gap_n;
      m_valid <= mv_n;
      m_data  <= md_n;
      m_user  <= mu_n;
      m_last  <= ml_n;
    end
  end

endmodule

// File: tb/tb_preamble_insertion.sv
// Directed testbench for preamble_insertion (default parameters).
// Anchor values: table entries scaled by 16384/200, truncated toward zero,
// word = {Q,I}.
module tb_preamble_insertion;

  localparam logic [31:0] STS0  = 32'h075C_075C;  // 0.023+0.023j
  localparam logic [31:0] STS1  = 32'h00A3_D5C3;  // -0.132+0.002j
  localparam logic [31:0] STS4  = 32'h0000_1D70;  // 0.092
  localparam logic [31:0] LTS0  = 32'h0000_31EB;  // 0.156
  localparam logic [31:0] LTS32 = 32'h0000_CE15;  // -0.156

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_user;
  logic        m_last;

  preamble_insertion #(.WIDTH(16), .SHORT_COUNT(10), .GAP(4)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [31:0] cap_data [0:699];
  logic [1:0]  cap_user [0:699];
  logic        cap_last [0:699];
  logic [31:0] ref_data [0:699];
  logic [1:0]  ref_user [0:699];
  logic        ref_last [0:699];
  logic [31:0] pay_d [0:7];
  logic        pay_l [0:7];

  int nb, pidx, plen, hole_at, hole_left, stall_pct;
  int bubble, sr_low, stall_events, hold_err;
  logic seen_last, after_last, hold_pend;
  logic [31:0] hold_d;
  logic [1:0]  hold_u;
  logic        hold_l;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    nb = 0; bubble = 0; sr_low = 0; stall_events = 0; hold_err = 0;
    seen_last = 1'b0; after_last = 1'b0; hold_pend = 1'b0;
  endtask

  task automatic drive();
    m_ready = ($urandom_range(0, 99) >= stall_pct);
    if (hole_left > 0) begin
      s_valid = 1'b0;
      hole_left--;
    end else if (pidx < plen) begin
      s_valid = 1'b1;
      s_data  = pay_d[pidx];
      s_last  = pay_l[pidx];
    end else begin
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
    end
  endtask

  task automatic observe();
    if (hold_pend && !(m_valid && m_data === hold_d && m_user === hold_u && m_last === hold_l))
      hold_err++;
    hold_pend = m_valid && !m_ready;
    hold_d = m_data; hold_u = m_user; hold_l = m_last;
    if (hold_pend) stall_events++;
    if (after_last) begin
      if (m_valid) after_last = 1'b0;
      else if (!s_ready) sr_low++;
    end
    if (nb > 0 && !seen_last && !m_valid) bubble++;
    if (m_valid && m_ready && nb < 700) begin
      cap_data[nb] = m_data; cap_user[nb] = m_user; cap_last[nb] = m_last;
      nb++;
      if (m_last) begin
        if (!seen_last) after_last = 1'b1;
        seen_last = 1'b1;
      end
    end
    if (s_valid && s_ready) begin
      pidx++;
      if (pidx == hole_at) begin
        hole_left = 3;
        hole_at   = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    drive();
    #1;
    observe();
  endtask

  task automatic run_beats(input int target, input int budget);
    int c;
    c = 0;
    while (nb < target && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic start_test(input int n, input int pct, input int hole);
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    plen = n; stall_pct = pct; hole_at = hole; hole_left = 0; pidx = 0;
    clear_capture();
    drive();
  endtask

  task automatic check_frame(input string t, input int base, input int npay, input int poff);
    int bu, bl, bp;
    bu = 0; bl = 0; bp = 0;
    for (int i = 0; i < 320 + npay; i++) begin
      logic [1:0] eu;
      eu = (i < 160) ? 2'd0 : ((i < 320) ? 2'd1 : 2'd2);
      if (cap_user[base+i] !== eu) bu++;
      if (cap_last[base+i] !== (i == 319 + npay)) bl++;
    end
    for (int k = 0; k < npay; k++)
      if (cap_data[base+320+k] !== pay_d[poff+k]) bp++;
    check({t, "_user_tags"}, bu, 0);
    check({t, "_last_flags"}, bl, 0);
    check({t, "_payload"}, bp, 0);
    check({t, "_sts0"}, cap_data[base], STS0);
    check({t, "_sts1"}, cap_data[base+1], STS1);
    check({t, "_sts4"}, cap_data[base+4], STS4);
    check({t, "_gi_lts32"}, cap_data[base+160], LTS32);
    check({t, "_lt1_lts0"}, cap_data[base+192], LTS0);
    check({t, "_lt2_lts32"}, cap_data[base+288], LTS32);
  endtask

  initial begin
    int bad;
    vectors = 0; miscompares = 0;
    plen = 0; pidx = 0; stall_pct = 0; hole_at = -1; hole_left = 0;
    clear_capture();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_user", m_user, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);

    // 1: four-sample frame, m_ready high
    pay_d[0] = 32'h0001_0001; pay_l[0] = 1'b0;
    pay_d[1] = 32'h0002_0002; pay_l[1] = 1'b0;
    pay_d[2] = 32'h0003_0003; pay_l[2] = 1'b0;
    pay_d[3] = 32'h0004_0004; pay_l[3] = 1'b1;
    start_test(4, 0, -1);
    run_beats(324, 1000);
    repeat (10) tick();
    check("t1_beats", nb, 324);
    check("t1_bubbles", bubble, 0);
    check_frame("t1", 0, 4, 0);
    for (int i = 0; i < 324; i++) begin
      ref_data[i] = cap_data[i]; ref_user[i] = cap_user[i]; ref_last[i] = cap_last[i];
    end

    // 2: periodicity of the preamble
    bad = 0;
    for (int k = 0; k < 144; k++) if (cap_data[k] !== cap_data[k+16]) bad++;
    check("t2_stf_period", bad, 0);
    bad = 0;
    for (int k = 0; k < 32; k++) if (cap_data[160+k] !== cap_data[224+k]) bad++;
    check("t2_gi_copy", bad, 0);
    bad = 0;
    for (int k = 0; k < 64; k++) if (cap_data[192+k] !== cap_data[256+k]) bad++;
    check("t2_lt_repeat", bad, 0);

    // 3: random 30% back-pressure
    start_test(4, 30, -1);
    run_beats(324, 3000);
    stall_pct = 0;
    repeat (10) tick();
    check("t3_beats", nb, 324);
    check("t3_hold_stable", hold_err, 0);
    check("t3_stalls_seen", stall_events > 0, 1);
    bad = 0;
    for (int i = 0; i < 324; i++)
      if (cap_data[i] !== ref_data[i] || cap_user[i] !== ref_user[i] || cap_last[i] !== ref_last[i])
        bad++;
    check("t3_same_sequence", bad, 0);
    check_frame("t3", 0, 4, 0);

    // 4: reset around beat 100
    start_test(4, 0, -1);
    run_beats(100, 400);
    check("t4_pre_reset_beats", nb, 100);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t4_reset_m_valid", m_valid, 0);
    check("t4_reset_s_ready", s_ready, 0);
    reset = 1'b0;
    clear_capture();
    check("t4_payload_untouched", pidx, 0);
    run_beats(324, 1000);
    repeat (10) tick();
    check("t4_beats", nb, 324);
    check_frame("t4", 0, 4, 0);

    // 5: two back-to-back one-sample frames
    pay_d[0] = 32'h1111_2222; pay_l[0] = 1'b1;
    pay_d[1] = 32'h3333_4444; pay_l[1] = 1'b1;
    start_test(2, 0, -1);
    run_beats(642, 2000);
    repeat (10) tick();
    check("t5_beats", nb, 642);
    check("t5_s_ready_low_ge4", sr_low >= 4, 1);
    check_frame("t5a", 0, 1, 0);
    check_frame("t5b", 321, 1, 1);

    // 6: payload underflow, 3-cycle s_valid hole after two samples
    pay_d[0] = 32'hA000_0001; pay_l[0] = 1'b0;
    pay_d[1] = 32'hA000_0002; pay_l[1] = 1'b0;
    pay_d[2] = 32'hA000_0003; pay_l[2] = 1'b0;
    pay_d[3] = 32'hA000_0004; pay_l[3] = 1'b0;
    pay_d[4] = 32'hA000_0005; pay_l[4] = 1'b1;
    start_test(5, 0, 2);
    run_beats(325, 1000);
    repeat (10) tick();
    check("t6_beats", nb, 325);
    check("t6_valid_low_cycles", bubble, 3);
    check_frame("t6", 0, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
